msg_word_packer: RTL

MSG_WORD_PACKER -- requirements
Module: msg_word_packer

---
 rtl/msg_word_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/msg_word_packer.sv
// msg_word_packer: packs a byte stream little-endian into W-bit words for the Dilithium core input bus.
// Define MSG_LEN_HDR_EN to emit a leading header word carrying the message length in bits.
module msg_word_packer #(
   parameter int W             = 64,
   parameter int MAX_MSG_BYTES = 3300,
   parameter int LEN_W         = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] msg_len_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic [W-1:0]     word_o,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic             word_last_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [2:0]       dbg_state
);

   // Handshakes: a byte moves on a rising edge where byte_valid_i && byte_ready_o, a word moves on
   // a rising edge where word_valid_o && word_ready_i; word_o/word_last_o hold while valid && !ready.

`ifdef MSG_LEN_HDR_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_FILL = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_cnt_q;
   logic [2:0]       idx_q;
   logic [W-1:0]     word_q;
   logic             err_q;

   logic len_ok;
   logic len_zero;
   logic byte_fire;
   logic word_fire;
   logic word_done;

   assign len_ok    = (msg_len_i <= LEN_W'(MAX_MSG_BYTES));
   assign len_zero  = (msg_len_i == '0);
   assign byte_fire = byte_valid_i && byte_ready_o;
   assign word_fire = word_valid_o && word_ready_i;
   // The transfer that fills lane 7 or consumes the final byte closes the word.
   assign word_done = (idx_q == 3'd7) || (rem_cnt_q == LEN_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && len_ok) begin
`ifdef MSG_LEN_HDR_EN
               state_d = S_HDR;
`else
               state_d = len_zero ? S_DONE : S_FILL;
`endif
            end
         end
         S_FILL: begin
            if (byte_fire && word_done) begin
               state_d = S_EMIT;
            end
         end
`ifdef MSG_LEN_HDR_EN
         S_HDR, S_EMIT: begin
`else
         S_EMIT: begin
`endif
            if (word_ready_i) begin
               state_d = (rem_cnt_q == '0) ? S_DONE : S_FILL;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_cnt_q <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (len_ok) begin
                     rem_cnt_q <= msg_len_i;
                     idx_q     <= '0;
`ifdef MSG_LEN_HDR_EN
                     word_q    <= W'(LEN_W'({msg_len_i, 3'b000}));
`else
                     word_q    <= '0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (byte_fire) begin
                  for (int k = 0; k < W / 8; k++) begin
                     if (idx_q == 3'(k)) begin
                        word_q[8*k +: 8] <= byte_i;
                     end
                  end
                  rem_cnt_q <= rem_cnt_q - LEN_W'(1);
                  idx_q     <= idx_q + 3'd1;
               end
            end
            default: begin
               // Start a fresh zeroed word so a short final word is padded with 0x00.
               if (word_fire && (rem_cnt_q != '0)) begin
                  word_q <= '0;
                  idx_q  <= '0;
               end
            end
         endcase
      end
   end

`ifdef MSG_LEN_HDR_EN
   assign word_valid_o = (state_q == S_EMIT) || (state_q == S_HDR);
`else
   assign word_valid_o = (state_q == S_EMIT);
`endif
   assign byte_ready_o = (state_q == S_FILL);
   assign word_o       = word_q;
   assign word_last_o  = word_valid_o && (rem_cnt_q == '0);
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = err_q;
   assign dbg_state    = state_q;

endmodule
